// File: rtl/ef_apb_wb_irq_bridge.sv
// ef_apb_wb_irq_bridge: APB slave to Wishbone master bridge with a flag interrupt controller.
// Define EF_APB_WB_TIMEOUT_EN to abort Wishbone transfers that wait TIMEOUT cycles without ack.
module ef_apb_wb_irq_bridge #(
  parameter int WB_DW   = 16,
  parameter int WB_AW   = 3,
  parameter int NUM_IRQ = 9,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [31:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic [WB_AW-1:0]   wb_adr_o,
  output logic [WB_DW-1:0]   wb_dat_o,
  input  logic [WB_DW-1:0]   wb_dat_i,
  output logic               wb_we_o,
  output logic [WB_DW/8-1:0] wb_sel_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  input  logic               wb_ack_i,
  input  logic [NUM_IRQ-1:0] flags,
  output logic               irq
);
  localparam int S = (WB_DW == 32) ? 2 : 1;
  typedef enum logic [1:0] {IDLE, LOCAL, WB, RESP} state_t;
  state_t r_state, w_next;
  logic [31:0] r_prdata, w_rdata;
  logic r_pready, r_pslverr, r_irq;
  logic [NUM_IRQ-1:0] r_im, r_edge, r_ris, r_flags_q, w_wdata, w_icr;
  logic [7:0] w_off;
  logic w_start, w_local, w_ack, w_tmo, w_unmap, w_wr, w_unused;
  assign w_start  = PSEL & PENABLE & ~PREADY;
  assign w_local  = PADDR[15:8] == 8'h0F;
  assign w_off    = PADDR[7:0];
  assign w_ack    = (r_state == WB) & wb_ack_i;
  assign w_wr     = (r_state == LOCAL) & PWRITE;
  assign w_wdata  = PWDATA[NUM_IRQ-1:0];
  assign w_icr    = (w_wr & (w_off == 8'h10)) ? w_wdata : '0;
  assign w_unused = ^{PADDR, PWDATA, TIMEOUT != 0};
  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign irq      = r_irq;
  assign wb_cyc_o = r_state == WB;
  assign wb_stb_o = r_state == WB;
  assign wb_we_o  = (r_state == WB) & PWRITE;
  assign wb_adr_o = PADDR[WB_AW+S-1:S];
  assign wb_dat_o = PWDATA[WB_DW-1:0];
  assign wb_sel_o = '1;
`ifdef EF_APB_WB_TIMEOUT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (r_state == WB) ? r_cnt + 16'd1 : '0;
  assign w_tmo = (r_state == WB) & ~wb_ack_i & (r_cnt == 16'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_local ? LOCAL : WB;
      LOCAL:   w_next = RESP;
      WB:      if (w_ack | w_tmo) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_unmap = 1'b0;
    w_rdata = '0;
    case (w_off)
      8'h04:   w_rdata = 32'(r_ris);
      8'h08:   w_rdata = 32'(r_im);
      8'h0C:   w_rdata = 32'(r_ris & r_im);
      8'h10:   w_rdata = '0;
      8'h14:   w_rdata = 32'(r_edge);
      default: begin
        w_unmap = 1'b1;
        w_rdata = 32'hDEADBEEF;
      end
    endcase
  end
  // Edge-mode bits: a new rising edge beats a same-cycle ICR clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_irq     <= 1'b0;
      r_im      <= '0;
      r_edge    <= '0;
      r_ris     <= '0;
      r_flags_q <= '0;
    end else begin
      r_flags_q <= flags;
      r_ris     <= (~r_edge & flags) | (r_edge & ((flags & ~r_flags_q) | (r_ris & ~w_icr)));
      r_irq     <= |(r_ris & r_im);
      r_pready  <= w_next == RESP;
      if (r_state == LOCAL) begin
        r_pslverr <= w_unmap;
        if (~PWRITE | w_unmap) r_prdata <= w_rdata;
        if (w_wr & (w_off == 8'h08)) r_im <= w_wdata;
        if (w_wr & (w_off == 8'h14)) r_edge <= w_wdata;
      end else if (w_ack) begin
        r_pslverr <= 1'b0;
        if (~PWRITE) r_prdata <= 32'(wb_dat_i);
      end else if (w_tmo) begin
        r_pslverr <= 1'b1;
        r_prdata  <= 32'hDEADBEEF;
      end else if (r_state == IDLE) r_pslverr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ef_apb_wb_irq_bridge.sv
// tb_ef_apb_wb_irq_bridge: scoreboard bench with a Wishbone slave model and an interrupt reference model.
module tb_ef_apb_wb_irq_bridge;
  logic clk = 0, rst = 1;
  logic PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [31:0] PADDR = 0, PWDATA = 0, PRDATA;
  logic PREADY, PSLVERR, wb_we_o, wb_cyc_o, wb_stb_o, irq;
  logic [2:0] wb_adr_o;
  logic [15:0] wb_dat_o, wb_dat_i = 0;
  logic [1:0] wb_sel_o;
  logic wb_ack_i = 0;
  logic [8:0] flags = 0;
  typedef struct {logic [31:0] d; bit cd; bit err;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  logic [8:0] m_ris = 0, m_im = 0, m_edge = 0, m_fq = 0, n_im, n_edge, icr, commit_pulse = 0;
  logic m_irq = 0;
  bit flag_rand = 0, c_v = 0, c_w = 0, s_we = 0;
  logic [31:0] c_a = 0, c_d = 0;
  int s_n = 0, s_delay = 0;
  logic [15:0] s_data = 0, s_dat = 0;
  logic [2:0] s_adr = 0;
  logic [7:0] offs [10] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h04, 8'h08, 8'h00, 8'h18, 8'hFC};

  ef_apb_wb_irq_bridge #(.WB_DW(16), .WB_AW(3), .NUM_IRQ(9), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .flags(flags), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", n, a, e);
    end
  endtask

  function automatic exp_t local_exp(input logic [7:0] off, input bit w);
    exp_t e;
    e.cd = 1;
    e.err = 0;
    case (off)
      8'h04:   e.d = {23'b0, m_ris};
      8'h08:   e.d = {23'b0, m_im};
      8'h0C:   e.d = {23'b0, m_ris & m_im};
      8'h10:   e.d = 0;
      8'h14:   e.d = {23'b0, m_edge};
      default: begin e.d = 32'hDEADBEEF; e.err = 1; end
    endcase
    if (w && !e.err) e.cd = 0;
    return e;
  endfunction

  // Reference model: register effects land on the edge that ends the local access cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ris = 0; m_im = 0; m_edge = 0; m_fq = 0; m_irq = 0;
    end else begin
      n_im = m_im;
      n_edge = m_edge;
      icr = 0;
      if (c_v) begin
        q.push_back(local_exp(c_a[7:0], c_w));
        if (c_w) case (c_a[7:0])
          8'h08: n_im = c_d[8:0];
          8'h10: icr = c_d[8:0];
          8'h14: n_edge = c_d[8:0];
          default: ;
        endcase
      end
      m_irq = (m_ris & m_im) != 0;
      for (int i = 0; i < 9; i++)
        if (!m_edge[i]) m_ris[i] = flags[i];
        else if (flags[i] && !m_fq[i]) m_ris[i] = 1;
        else if (icr[i]) m_ris[i] = 0;
      m_fq = flags;
      m_im = n_im;
      m_edge = n_edge;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      wb_ack_i = 0;
      s_n = 0;
    end else if (wb_ack_i) begin
      wb_ack_i = 0;
      s_n = 0;
      chk("cyc_after_ack", wb_cyc_o, 0);
    end else if (wb_cyc_o) begin
      s_n++;
      if (s_n == s_delay) begin
        chk("wb_adr", wb_adr_o, s_adr);
        chk("wb_we", wb_we_o, s_we);
        chk("wb_stb", wb_stb_o, 1);
        chk("wb_sel", wb_sel_o, 2'b11);
        if (s_we) chk("wb_dat", wb_dat_o, s_dat);
        wb_dat_i = s_data;
        wb_ack_i = 1;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("irq", irq, m_irq);
    if (PREADY) begin
      if (q.size() == 0) chk("unexpected_pready", PREADY, 0);
      else begin
        mon_e = q.pop_front();
        chk("pslverr", PSLVERR, mon_e.err);
        if (mon_e.cd) chk("prdata", PRDATA, mon_e.d);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (flag_rand) flags = 9'($urandom & $urandom);
  endtask

  task automatic apb(input logic [31:0] a, input bit w, input logic [31:0] d, input int dly, input logic [15:0] sd);
    bit loc;
    loc = a[15:8] == 8'h0F;
    if (!loc) begin
      s_delay = dly; s_data = sd; s_we = w; s_adr = 3'((a >> 1) & 7); s_dat = d[15:0];
      q.push_back('{w ? 32'h0 : {16'h0, sd}, !w, 1'b0});
    end
    PSEL = 1; PWRITE = w; PADDR = a; PWDATA = d; PENABLE = 0;
    tick();
    PENABLE = 1;
    tick();
    if (loc) begin
      c_v = 1; c_w = w; c_a = a; c_d = d;
      flags = flags | commit_pulse;
    end
    tick();
    c_v = 0;
    for (int n = 0; n < 64 && !PREADY; n++) tick();
    chk("pready_seen", PREADY, 1);
    PSEL = 0; PENABLE = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    repeat (3) tick();
    chk("rst_prdata", PRDATA, 0);
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_irq", irq, 0);
    rst = 0;
    tick();
    apb(32'h0000_0004, 1, 32'h0000_1234, 3, 16'h0);
    apb(32'h0000_0008, 0, 32'h0, 2, 16'hBEEF);
    apb(32'h0000_0F14, 1, 32'h1, 0, 0);
    apb(32'h0000_0F08, 1, 32'h1, 0, 0);
    tick(); flags = 9'h001; tick(); flags = 0;
    repeat (3) tick();
    apb(32'h0000_0F04, 0, 0, 0, 0);
    apb(32'h0000_0F10, 1, 32'h1, 0, 0);
    apb(32'h0000_0F04, 0, 0, 0, 0);
    commit_pulse = 9'h001;
    apb(32'h0000_0F10, 1, 32'h1, 0, 0);
    commit_pulse = 0;
    flags = 0;
    apb(32'h0000_0F04, 0, 0, 0, 0);
    apb(32'h0000_0F14, 1, 32'h0, 0, 0);
    apb(32'h0000_0F08, 1, 32'hFFFF_FF00, 0, 0);
    flags = 9'h100;
    tick();
    apb(32'h0000_0F0C, 0, 0, 0, 0);
    flags = 0;
    repeat (4) tick();
    apb(32'h0000_0F20, 0, 0, 0, 0);
    apb(32'h0000_0F20, 1, 32'h1, 0, 0);
    apb(32'hABCD_0F08, 0, 0, 0, 0);
    flag_rand = 1;
    repeat (60) begin
      a = $urandom;
      if ($urandom_range(0, 3) < 2) begin
        if (a[15:8] == 8'h0F) a[8] = ~a[8];
        apb(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 5), 16'($urandom));
      end else begin
        a[15:0] = {8'h0F, offs[$urandom_range(0, 9)]};
        apb(a, 1'($urandom_range(0, 1)), $urandom, 0, 0);
      end
    end
    flag_rand = 0;
    flags = 0;
    tick();
    s_delay = -1;
    PSEL = 1; PWRITE = 0; PADDR = 32'h10; PENABLE = 0;
    tick();
    PENABLE = 1;
    tick(); tick();
    chk("cyc_in_wait", wb_cyc_o, 1);
    #2 rst = 1;
    #1;
    chk("arst_cyc", wb_cyc_o, 0);
    chk("arst_stb", wb_stb_o, 0);
    chk("arst_we", wb_we_o, 0);
    chk("arst_pready", PREADY, 0);
    chk("arst_prdata", PRDATA, 0);
    chk("arst_pslverr", PSLVERR, 0);
    chk("arst_irq", irq, 0);
    PSEL = 0; PENABLE = 0;
    tick(); tick();
    rst = 0;
    tick();
    apb(32'h0000_0006, 1, 32'h0000_CAFE, 1, 0);
    apb(32'h0000_0F08, 0, 0, 0, 0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
